// File: rtl/mxv_uart_pkg.sv
// Shared definitions for the UART link control units: receive FSM states,
// ASCII digit bounds and default frame geometry.
package mxv_uart_pkg;

  // Digit position expected next; digits arrive ones first.
  typedef enum logic [1:0] {
    WAIT_ONES = 2'd0,
    WAIT_TENS = 2'd1,
    WAIT_HUND = 2'd2
  } rx_state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;

  localparam int DEF_NUM_ELEM = 8;
  localparam int DEF_VAL_W    = 10;

  // True for bytes '0'..'9'.
  function automatic logic is_ascii_digit(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

endpackage

// File: rtl/bcd3_to_bin.sv
// Three decimal digits to binary using only shifts and adds:
// h*100 = h*64 + h*32 + h*4, t*10 = t*8 + t*2.
module bcd3_to_bin #(
  parameter int VAL_W = mxv_uart_pkg::DEF_VAL_W
) (
  input  logic [3:0]       hund,
  input  logic [3:0]       tens,
  input  logic [3:0]       ones,
  output logic [VAL_W-1:0] value
);

  logic [VAL_W-1:0] hund_ext;
  logic [VAL_W-1:0] tens_ext;
  logic [VAL_W-1:0] ones_ext;

  assign hund_ext = {{(VAL_W-4){1'b0}}, hund};
  assign tens_ext = {{(VAL_W-4){1'b0}}, tens};
  assign ones_ext = {{(VAL_W-4){1'b0}}, ones};

  // Shift-add weighting of each digit; VAL_W is wide enough for 999.
  always_comb begin
    value = (hund_ext << 6) + (hund_ext << 5) + (hund_ext << 2)
          + (tens_ext << 3) + (tens_ext << 1)
          + ones_ext;
  end

endmodule

// File: rtl/ctl_unit_recvrx.sv
// Receive-side control unit: parses ASCII decimal digit triplets (ones,
// tens, hundreds) from the UART receiver into binary frame elements and
// reports element index, frame completion and frame aborts.
module ctl_unit_recvrx
  import mxv_uart_pkg::*;
#(
  parameter int NUM_ELEM    = DEF_NUM_ELEM,
  parameter int VAL_W       = DEF_VAL_W,
  parameter int IDX_W       = $clog2(NUM_ELEM),
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ENABLE,
  input  logic             RX_VALID,
  input  logic [7:0]       RX_DATA,
  output logic [VAL_W-1:0] ELEM_VALUE,
  output logic [IDX_W-1:0] ELEM_IDX,
  output logic             ELEM_VALID,
  output logic             FRAME_DONE,
  output logic             FRAME_ERR,
  output logic             BUSY
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_ELEM - 1);

  rx_state_t        state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [3:0]       ones_reg, ones_next;
  logic [3:0]       tens_reg, tens_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [VAL_W-1:0] value_reg, value_next;
  logic [IDX_W-1:0] elem_idx_reg, elem_idx_next;
  logic             valid_reg, valid_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;

  logic             idle;
  logic             rx_is_digit;
  logic [3:0]       rx_digit;
  logic [VAL_W-1:0] group_value;

  assign idle        = (state_reg == WAIT_ONES) && (idx_reg == '0);
  assign rx_is_digit = is_ascii_digit(RX_DATA);
  // For '0'..'9' the low nibble already equals RX_DATA - '0'.
  assign rx_digit    = RX_DATA[3:0];

  // The hundreds digit is taken straight from the bus so the element is
  // registered on the same edge that samples the hundreds byte.
  bcd3_to_bin #(
    .VAL_W (VAL_W)
  ) u_bcd3_to_bin (
    .hund  (rx_digit),
    .tens  (tens_reg),
    .ones  (ones_reg),
    .value (group_value)
  );

  // Next-state logic: digit parsing, frame sequencing, abort and timeout.
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    ones_next     = ones_reg;
    tens_next     = tens_reg;
    cnt_next      = cnt_reg;
    value_next    = value_reg;
    elem_idx_next = elem_idx_reg;
    valid_next    = 1'b0;
    done_next     = 1'b0;
    err_next      = 1'b0;

    if (!ENABLE) begin
      // Disarmed: discard any partial frame quietly.
      state_next = WAIT_ONES;
      idx_next   = '0;
      cnt_next   = '0;
    end else if (RX_VALID) begin
      // A byte always restarts the idle timer, even on the expiry cycle.
      cnt_next = '0;
      if (rx_is_digit) begin
        case (state_reg)
          WAIT_ONES: begin
            ones_next  = rx_digit;
            state_next = WAIT_TENS;
          end
          WAIT_TENS: begin
            tens_next  = rx_digit;
            state_next = WAIT_HUND;
          end
          WAIT_HUND: begin
            state_next    = WAIT_ONES;
            value_next    = group_value;
            elem_idx_next = idx_reg;
            valid_next    = 1'b1;
            if (idx_reg == IDX_LAST) begin
              done_next = 1'b1;
              idx_next  = '0;
            end else begin
              idx_next = idx_reg + IDX_W'(1);
            end
          end
          default: state_next = WAIT_ONES;
        endcase
      end else if (!idle) begin
        // Garbage inside a frame aborts it; between frames it is ignored.
        err_next   = 1'b1;
        state_next = WAIT_ONES;
        idx_next   = '0;
      end
    end else if (idle) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_LAST) begin
      err_next   = 1'b1;
      state_next = WAIT_ONES;
      idx_next   = '0;
      cnt_next   = '0;
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= WAIT_ONES;
      idx_reg      <= '0;
      ones_reg     <= '0;
      tens_reg     <= '0;
      cnt_reg      <= '0;
      value_reg    <= '0;
      elem_idx_reg <= '0;
      valid_reg    <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      ones_reg     <= ones_next;
      tens_reg     <= tens_next;
      cnt_reg      <= cnt_next;
      value_reg    <= value_next;
      elem_idx_reg <= elem_idx_next;
      valid_reg    <= valid_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  assign ELEM_VALUE = value_reg;
  assign ELEM_IDX   = elem_idx_reg;
  assign ELEM_VALID = valid_reg;
  assign FRAME_DONE = done_reg;
  assign FRAME_ERR  = err_reg;
  assign BUSY       = !idle;

endmodule

// File: tb/tb_ctl_unit_recvrx.sv
// Directed self-checking bench for ctl_unit_recvrx (idle timeout shortened
// to 20 clocks). Inputs change on the falling edge, outputs are read there.
module tb_ctl_unit_recvrx;

  logic       clk = 1'b0;
  logic       reset;
  logic       ENABLE;
  logic       RX_VALID;
  logic [7:0] RX_DATA;
  logic [9:0] ELEM_VALUE;
  logic [2:0] ELEM_IDX;
  logic       ELEM_VALID;
  logic       FRAME_DONE;
  logic       FRAME_ERR;
  logic       BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ctl_unit_recvrx #(
    .NUM_ELEM    (8),
    .VAL_W       (10),
    .IDX_W       (3),
    .TIMEOUT_CYC (20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ENABLE     (ENABLE),
    .RX_VALID   (RX_VALID),
    .RX_DATA    (RX_DATA),
    .ELEM_VALUE (ELEM_VALUE),
    .ELEM_IDX   (ELEM_IDX),
    .ELEM_VALID (ELEM_VALID),
    .FRAME_DONE (FRAME_DONE),
    .FRAME_ERR  (FRAME_ERR),
    .BUSY       (BUSY)
  );

  // One-cycle strobe; called and returns on a falling edge, so the DUT
  // response to this byte is visible when it returns.
  task automatic put(input logic [7:0] b);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    @(negedge clk);
    RX_VALID = 1'b0;
    RX_DATA  = 8'h00;
  endtask

  // Ones, tens, hundreds on consecutive clocks.
  task automatic put_group(input int v);
    put(8'h30 + 8'(v % 10));
    put(8'h30 + 8'((v / 10) % 10));
    put(8'h30 + 8'(v / 100));
  endtask

  task automatic test_reset;
    reset = 1'b1; ENABLE = 1'b0; RX_VALID = 1'b0; RX_DATA = 8'h00;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ELEM_VALUE, ELEM_IDX, ELEM_VALID, FRAME_DONE, FRAME_ERR, BUSY} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got val=%0d idx=%0d v=%b d=%b e=%b b=%b, required all 0",
               ELEM_VALUE, ELEM_IDX, ELEM_VALID, FRAME_DONE, FRAME_ERR, BUSY);
    end
    reset = 1'b0; ENABLE = 1'b1;
    @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_single;
    put("5");
    put("2");
    n_checks++;
    if (ELEM_VALID !== 1'b0 || BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL single_partial: got valid=%b busy=%b, required valid=0 busy=1", ELEM_VALID, BUSY);
    end
    put("1");
    n_checks++;
    if (ELEM_VALID !== 1'b1 || ELEM_VALUE !== 10'd125 || ELEM_IDX !== 3'd0 ||
        BUSY !== 1'b1 || FRAME_DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL single_elem: got v=%b val=%0d idx=%0d busy=%b done=%b, required 1/125/0/1/0",
               ELEM_VALID, ELEM_VALUE, ELEM_IDX, BUSY, FRAME_DONE);
    end
    $display("single: value=%0d idx=%0d", ELEM_VALUE, ELEM_IDX);
    @(negedge clk);
    n_checks++;
    if (ELEM_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pulse_width: got valid=%b one cycle later, required 0", ELEM_VALID);
    end
  endtask

  task automatic test_enable_discard;
    ENABLE = 1'b0;
    put("9");
    n_checks++;
    if (BUSY !== 1'b0 || FRAME_ERR !== 1'b0 || ELEM_VALUE !== 10'd125 || ELEM_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_discard: got busy=%b err=%b val=%0d v=%b, required 0/0/125/0",
               BUSY, FRAME_ERR, ELEM_VALUE, ELEM_VALID);
    end
    ENABLE = 1'b1;
    @(negedge clk);
    $display("enable: partial frame discarded, busy=%b", BUSY);
  endtask

  task automatic test_frame;
    int vals [8] = '{0, 1, 9, 10, 99, 100, 998, 999};
    for (int i = 0; i < 8; i++) begin
      put_group(vals[i]);
      n_checks++;
      if (ELEM_VALID !== 1'b1 || ELEM_VALUE !== 10'(vals[i]) || ELEM_IDX !== 3'(i) ||
          FRAME_DONE !== (i == 7)) begin
        n_fail++;
        $display("FAIL frame_elem%0d: got v=%b val=%0d idx=%0d done=%b, required 1/%0d/%0d/%b",
                 i, ELEM_VALID, ELEM_VALUE, ELEM_IDX, FRAME_DONE, vals[i], i, (i == 7));
      end
      $display("frame: value=%0d idx=%0d done=%b", ELEM_VALUE, ELEM_IDX, FRAME_DONE);
    end
    n_checks++;
    if (BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_busy_after: got %b, required 0", BUSY);
    end
  endtask

  task automatic test_crlf;
    put(8'h0D);
    put(8'h0A);
    n_checks++;
    if (FRAME_ERR !== 1'b0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL crlf_ignored: got err=%b busy=%b, required 0/0", FRAME_ERR, BUSY);
    end
    put_group(7);
    n_checks++;
    if (ELEM_VALID !== 1'b1 || ELEM_VALUE !== 10'd7 || ELEM_IDX !== 3'd0 || FRAME_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL crlf_elem: got v=%b val=%0d idx=%0d err=%b, required 1/7/0/0",
               ELEM_VALID, ELEM_VALUE, ELEM_IDX, FRAME_ERR);
    end
    $display("crlf: value=%0d idx=%0d", ELEM_VALUE, ELEM_IDX);
  endtask

  task automatic test_nondigit;
    put("3");
    put("4");
    put(8'h41);
    n_checks++;
    if (FRAME_ERR !== 1'b1 || BUSY !== 1'b0 || ELEM_VALUE !== 10'd7 || ELEM_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL nondigit_abort: got err=%b busy=%b val=%0d v=%b, required 1/0/7/0",
               FRAME_ERR, BUSY, ELEM_VALUE, ELEM_VALID);
    end
    $display("nondigit: frame aborted");
    put_group(1);
    n_checks++;
    if (ELEM_VALID !== 1'b1 || ELEM_VALUE !== 10'd1 || ELEM_IDX !== 3'd0 || FRAME_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL nondigit_recover: got v=%b val=%0d idx=%0d err=%b, required 1/1/0/0",
               ELEM_VALID, ELEM_VALUE, ELEM_IDX, FRAME_ERR);
    end
    $display("nondigit: value=%0d idx=%0d", ELEM_VALUE, ELEM_IDX);
    ENABLE = 1'b0;
    @(negedge clk);
    ENABLE = 1'b1;
  endtask

  task automatic test_timeout;
    // Silence after one digit: abort visible exactly 20 clocks after the strobe.
    put("3");
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (FRAME_ERR !== (k == 20)) begin
        n_fail++;
        $display("FAIL timeout_err_cycle%0d: got %b, required %b", k, FRAME_ERR, (k == 20));
      end
    end
    n_checks++;
    if (BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_busy: got %b, required 0", BUSY);
    end
    $display("timeout: abort after 20 idle clocks");
    // Byte on the expiry cycle wins and restarts the timer.
    put("3");
    repeat (19) @(negedge clk);
    put("4");
    n_checks++;
    if (FRAME_ERR !== 1'b0 || BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_byte_wins: got err=%b busy=%b, required 0/1", FRAME_ERR, BUSY);
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (FRAME_ERR !== (k == 20)) begin
        n_fail++;
        $display("FAIL timeout_restart_cycle%0d: got %b, required %b", k, FRAME_ERR, (k == 20));
      end
    end
    $display("timeout: byte on expiry cycle processed, timer restarted");
  endtask

  task automatic test_reset_midframe;
    put_group(11);
    put_group(22);
    put_group(33);
    put_group(44);
    put("6");
    n_checks++;
    if (BUSY !== 1'b1 || ELEM_VALUE !== 10'd44 || ELEM_IDX !== 3'd3) begin
      n_fail++;
      $display("FAIL midframe_setup: got busy=%b val=%0d idx=%0d, required 1/44/3", BUSY, ELEM_VALUE, ELEM_IDX);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({ELEM_VALUE, ELEM_IDX, ELEM_VALID, FRAME_DONE, FRAME_ERR, BUSY} !== 17'd0) begin
      n_fail++;
      $display("FAIL midframe_async_clear: got val=%0d idx=%0d v=%b d=%b e=%b b=%b, required all 0",
               ELEM_VALUE, ELEM_IDX, ELEM_VALID, FRAME_DONE, FRAME_ERR, BUSY);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (FRAME_ERR !== 1'b0 || ELEM_VALID !== 1'b0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_no_pulse: got err=%b v=%b busy=%b, required 0/0/0", FRAME_ERR, ELEM_VALID, BUSY);
    end
    put_group(240);
    n_checks++;
    if (ELEM_VALID !== 1'b1 || ELEM_VALUE !== 10'd240 || ELEM_IDX !== 3'd0) begin
      n_fail++;
      $display("FAIL midframe_restart: got v=%b val=%0d idx=%0d, required 1/240/0", ELEM_VALID, ELEM_VALUE, ELEM_IDX);
    end
    $display("midframe reset: value=%0d idx=%0d", ELEM_VALUE, ELEM_IDX);
  endtask

  initial begin
    reset = 1'b1; ENABLE = 1'b0; RX_VALID = 1'b0; RX_DATA = 8'h00;
    @(negedge clk);
    test_reset();
    test_single();
    test_enable_discard();
    test_frame();
    test_crlf();
    test_nondigit();
    test_timeout();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
